// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - floor width, default floor count and panel state shared by the elevator blocks
package elevator_pkg;

  localparam int FLOOR_W        = 3;
  localparam int DEF_NUM_FLOORS = 5;
  localparam int GAP_W          = 8;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    PRESS,
    GAP
  } panel_state_t;

endpackage

// File: rtl/elevator_call_panel_if.sv
// rtl/elevator_call_panel_if.sv - call panel bus: button/status inputs, request strobe and lamp outputs
interface elevator_call_panel_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
);

  logic [NUM_FLOORS-1:0] btn;
  logic                  stop;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  press;
  logic [FLOOR_W-1:0]    dest_floor;
  logic [NUM_FLOORS-1:0] lamp;
  logic                  busy;

  modport master (
    input  btn, stop, current_floor,
    output press, dest_floor, lamp, busy
  );

  modport slave (
    output btn, stop, current_floor,
    input  press, dest_floor, lamp, busy
  );

endinterface

// File: rtl/call_rr_pick.sv
// rtl/call_rr_pick.sv - combinational round-robin picker: first set candidate at or after ptr, wrapping at N
module call_rr_pick
  import elevator_pkg::*;
#(
  parameter int N = elevator_pkg::DEF_NUM_FLOORS,
  parameter int W = elevator_pkg::FLOOR_W
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         found
);

  function automatic logic [W-1:0] rot_idx(input logic [W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[rot_idx(ptr, k)]) begin
        sel   = rot_idx(ptr, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - captures call buttons into a pending bitmap and serialises them as press pulses
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W,
  parameter int GAP_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  elevator_call_panel_if.master bus
);

  logic [NUM_FLOORS-1:0] btn_q;
  logic [NUM_FLOORS-1:0] pend;
  logic [NUM_FLOORS-1:0] sent;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] svc;
  logic [NUM_FLOORS-1:0] cand;
  logic [NUM_FLOORS-1:0] sent_set;
  logic                  armed;
  logic [FLOOR_W-1:0]    ptr;
  logic [FLOOR_W-1:0]    sel_q;
  logic [FLOOR_W-1:0]    dest_q;
  logic [FLOOR_W-1:0]    pick_sel;
  logic                  pick_found;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  load_sel;
  logic                  fire;
  panel_state_t          state;
  panel_state_t          state_nxt;

  // btn_q is forced to zero by reset, so the first cycle afterwards only
  // samples the buttons; a button held through reset must not count as a rise.
  assign rise = bus.btn & ~btn_q & {NUM_FLOORS{armed}};
  assign cand = pend & ~sent;

  always_comb begin
    svc = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      svc[i] = bus.stop && (bus.current_floor == FLOOR_W'(i));
    end
  end

  call_rr_pick #(
    .N (NUM_FLOORS),
    .W (FLOOR_W)
  ) u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .sel   (pick_sel),
    .found (pick_found)
  );

  always_comb begin
    state_nxt = state;
    load_sel  = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) state_nxt = SELECT;
      end
      SELECT: begin
        if (pick_found) begin
          load_sel  = 1'b1;
          state_nxt = PRESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      PRESS: begin
        // A call serviced between selection and issue is dropped silently.
        if (pend[sel_q] && !svc[sel_q]) begin
          fire      = 1'b1;
          state_nxt = GAP;
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sent_set = fire ? (NUM_FLOORS'(1) << sel_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      btn_q   <= '0;
      armed   <= 1'b0;
      pend    <= '0;
      sent    <= '0;
      ptr     <= '0;
      sel_q   <= '0;
      dest_q  <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      btn_q <= bus.btn;
      armed <= 1'b1;
      pend  <= (pend | rise) & ~svc;
      sent  <= (sent | sent_set) & ~svc;
      if (load_sel) sel_q <= pick_sel;
      if (fire) begin
        dest_q  <= sel_q;
        ptr     <= (sel_q == FLOOR_W'(NUM_FLOORS - 1)) ? '0 : sel_q + 1'b1;
        gap_cnt <= GAP_W'(GAP_CYCLES);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // During the pulse cycle dest_floor shows the selection directly; it is
  // captured on the pulse and held, so it only ever moves with a press.
  assign bus.press      = fire;
  assign bus.dest_floor = fire ? sel_q : dest_q;
  assign bus.lamp       = pend;
  assign bus.busy       = (state != IDLE) | (|cand);

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - directed self-checking bench for elevator_call_panel
module tb_elevator_call_panel;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  elevator_call_panel_if #(.NUM_FLOORS(5), .FLOOR_W(3)) bus ();

  elevator_call_panel #(
    .NUM_FLOORS (5),
    .FLOOR_W    (3),
    .GAP_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn = 5'b00110;
    for (int c = 0; c < 11; c++) begin
      next_edge();
      if (c == 3) rst = 1'b0;
      #2;
      checks++;
      if (bus.press !== 1'b0) begin errors++; $display("FAIL reset_press c=%0d: got %b expected 0", c, bus.press); end
      checks++;
      if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL reset_lamp c=%0d: got %b expected 00000", c, bus.lamp); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy c=%0d: got %b expected 0", c, bus.busy); end
    end
    bus.btn = 5'b00000;
    next_edge();
  endtask

  task automatic test_two_calls();
    logic       ep;
    logic [2:0] ed;
    next_edge();
    bus.btn = 5'b10100;
    for (int c = 0; c < 9; c++) begin
      next_edge();
      #2;
      ep = (c == 2) || (c == 7);
      ed = (c < 2) ? 3'd0 : ((c < 7) ? 3'd2 : 3'd4);
      checks++;
      if (bus.press !== ep) begin errors++; $display("FAIL two_press c=%0d: got %b expected %b", c, bus.press, ep); end
      checks++;
      if (bus.dest_floor !== ed) begin errors++; $display("FAIL two_dest c=%0d: got %0d expected %0d", c, bus.dest_floor, ed); end
    end
    bus.btn = 5'b00000;
    repeat (3) next_edge();
    #2;
    checks++;
    if (bus.lamp !== 5'b10100) begin errors++; $display("FAIL two_lamp: got %b expected 10100", bus.lamp); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL two_busy: got %b expected 0", bus.busy); end
    bus.stop = 1'b1;
    bus.current_floor = 3'd2;
    next_edge();
    #2;
    checks++;
    if (bus.lamp !== 5'b10000) begin errors++; $display("FAIL two_clr2: got %b expected 10000", bus.lamp); end
    bus.current_floor = 3'd4;
    next_edge();
    bus.stop = 1'b0;
    #2;
    checks++;
    if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL two_clr4: got %b expected 00000", bus.lamp); end
  endtask

  task automatic test_single();
    logic       ep;
    logic [2:0] ed;
    next_edge();
    bus.btn = 5'b00010;
    for (int c = 0; c < 6; c++) begin
      next_edge();
      #2;
      ep = (c == 2);
      ed = (c < 2) ? 3'd4 : 3'd1;
      checks++;
      if (bus.press !== ep) begin errors++; $display("FAIL single_press c=%0d: got %b expected %b", c, bus.press, ep); end
      checks++;
      if (bus.dest_floor !== ed) begin errors++; $display("FAIL single_dest c=%0d: got %0d expected %0d", c, bus.dest_floor, ed); end
      checks++;
      if (bus.lamp !== 5'b00010) begin errors++; $display("FAIL single_lamp c=%0d: got %b expected 00010", c, bus.lamp); end
    end
    bus.btn = 5'b00000;
    repeat (2) next_edge();
    #2;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", bus.busy); end
    bus.btn = 5'b00010;
    for (int c = 0; c < 5; c++) begin
      next_edge();
      #2;
      checks++;
      if (bus.press !== 1'b0) begin errors++; $display("FAIL single_repress c=%0d: got %b expected 0", c, bus.press); end
    end
    bus.btn = 5'b00000;
    bus.stop = 1'b1;
    bus.current_floor = 3'd1;
    next_edge();
    bus.stop = 1'b0;
    #2;
    checks++;
    if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL single_clear: got %b expected 00000", bus.lamp); end
  endtask

  task automatic test_round_robin();
    logic       ep;
    logic [2:0] ed;
    next_edge();
    bus.btn = 5'b01001;
    for (int c = 0; c < 9; c++) begin
      next_edge();
      #2;
      ep = (c == 2) || (c == 7);
      ed = (c < 2) ? 3'd1 : ((c < 7) ? 3'd3 : 3'd0);
      checks++;
      if (bus.press !== ep) begin errors++; $display("FAIL rr_press c=%0d: got %b expected %b", c, bus.press, ep); end
      checks++;
      if (bus.dest_floor !== ed) begin errors++; $display("FAIL rr_dest c=%0d: got %0d expected %0d", c, bus.dest_floor, ed); end
    end
    bus.btn = 5'b00000;
    repeat (3) next_edge();
    bus.stop = 1'b1;
    bus.current_floor = 3'd0;
    next_edge();
    bus.current_floor = 3'd3;
    next_edge();
    bus.stop = 1'b0;
    #2;
    checks++;
    if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL rr_clear: got %b expected 00000", bus.lamp); end
  endtask

  task automatic test_set_clear();
    logic       ep;
    logic [2:0] ed;
    next_edge();
    bus.btn = 5'b01000;
    bus.stop = 1'b1;
    bus.current_floor = 3'd3;
    next_edge();
    bus.stop = 1'b0;
    #2;
    checks++;
    if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL sc_lamp: got %b expected 00000", bus.lamp); end
    for (int c = 0; c < 4; c++) begin
      next_edge();
      #2;
      checks++;
      if (bus.press !== 1'b0) begin errors++; $display("FAIL sc_nopress c=%0d: got %b expected 0", c, bus.press); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL sc_busy c=%0d: got %b expected 0", c, bus.busy); end
    end
    bus.btn = 5'b00000;
    next_edge();
    bus.btn = 5'b01000;
    for (int c = 0; c < 4; c++) begin
      next_edge();
      #2;
      ep = (c == 2);
      ed = (c < 2) ? 3'd0 : 3'd3;
      checks++;
      if (bus.press !== ep) begin errors++; $display("FAIL sc_press c=%0d: got %b expected %b", c, bus.press, ep); end
      checks++;
      if (bus.dest_floor !== ed) begin errors++; $display("FAIL sc_dest c=%0d: got %0d expected %0d", c, bus.dest_floor, ed); end
    end
    bus.btn = 5'b00000;
    repeat (3) next_edge();
    bus.stop = 1'b1;
    bus.current_floor = 3'd7;
    next_edge();
    bus.current_floor = 3'd5;
    next_edge();
    #2;
    checks++;
    if (bus.lamp !== 5'b01000) begin errors++; $display("FAIL sc_range: got %b expected 01000", bus.lamp); end
    bus.current_floor = 3'd3;
    next_edge();
    bus.stop = 1'b0;
    #2;
    checks++;
    if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL sc_clear: got %b expected 00000", bus.lamp); end
  endtask

  task automatic test_service_before_issue();
    next_edge();
    bus.btn = 5'b00010;
    repeat (3) next_edge();
    bus.stop = 1'b1;
    bus.current_floor = 3'd1;
    #2;
    checks++;
    if (bus.press !== 1'b0) begin errors++; $display("FAIL sbi_press: got %b expected 0", bus.press); end
    checks++;
    if (bus.dest_floor !== 3'd3) begin errors++; $display("FAIL sbi_dest: got %0d expected 3", bus.dest_floor); end
    next_edge();
    bus.stop = 1'b0;
    bus.btn = 5'b00000;
    #2;
    checks++;
    if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL sbi_lamp: got %b expected 00000", bus.lamp); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL sbi_busy: got %b expected 0", bus.busy); end
    for (int c = 0; c < 4; c++) begin
      next_edge();
      #2;
      checks++;
      if (bus.press !== 1'b0) begin errors++; $display("FAIL sbi_after c=%0d: got %b expected 0", c, bus.press); end
    end
  endtask

  task automatic test_reset_mid();
    logic       ep;
    logic [2:0] ed;
    next_edge();
    bus.btn = 5'b01010;
    for (int c = 0; c < 4; c++) begin
      next_edge();
      #2;
      ep = (c == 2);
      ed = (c < 2) ? 3'd3 : 3'd1;
      checks++;
      if (bus.press !== ep) begin errors++; $display("FAIL rm_press c=%0d: got %b expected %b", c, bus.press, ep); end
      checks++;
      if (bus.dest_floor !== ed) begin errors++; $display("FAIL rm_dest c=%0d: got %0d expected %0d", c, bus.dest_floor, ed); end
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b expected 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.press !== 1'b0) begin errors++; $display("FAIL rm_press_rst: got %b expected 0", bus.press); end
    checks++;
    if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL rm_lamp_rst: got %b expected 00000", bus.lamp); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy_rst: got %b expected 0", bus.busy); end
    checks++;
    if (bus.dest_floor !== 3'd0) begin errors++; $display("FAIL rm_dest_rst: got %0d expected 0", bus.dest_floor); end
    repeat (2) next_edge();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next_edge();
      #2;
      checks++;
      if (bus.press !== 1'b0) begin errors++; $display("FAIL rm_after_press c=%0d: got %b expected 0", c, bus.press); end
      checks++;
      if (bus.lamp !== 5'b00000) begin errors++; $display("FAIL rm_after_lamp c=%0d: got %b expected 00000", c, bus.lamp); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_after_busy c=%0d: got %b expected 0", c, bus.busy); end
    end
    bus.btn = 5'b00000;
    next_edge();
  endtask

  initial begin
    rst = 1'b1;
    bus.btn = '0;
    bus.stop = 1'b0;
    bus.current_floor = '0;
    test_reset();
    test_two_calls();
    test_single();
    test_round_robin();
    test_set_clear();
    test_service_before_issue();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
